// File: rtl/clock_div_multi.sv
// Purpose: CH independent programmable clock dividers (tick pulse + 50% square) with hitless divisor reload.
// Latency: tick/sq/load_ack/load_err are registered; each reflects the inputs sampled on the previous edge.
// Backpressure: none; every load strobe is accepted or rejected in its own cycle, nothing stalls.
module clock_div_multi #(
  parameter int W       = 30,
  parameter int CH      = 4,
  parameter int DEF_DIV = 12500000,
  parameter int CW      = 2
) (
  input  logic          clk,
  input  logic          rs,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          load,
  input  logic [CW-1:0] load_ch,
  input  logic [W-1:0]  load_div,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] sq,
  output logic          load_ack,
  output logic          load_err
);

  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

  logic        load_in_range;
  logic        load_ok;
  logic [31:0] load_ch_ext;

  // Classify the load strobe: a valid channel and a non-zero divisor are required.
  always_comb begin
    load_ch_ext   = 32'(load_ch);
    load_in_range = (load_ch_ext < 32'(CH));
    load_ok       = load && load_in_range && (load_div != '0);
  end

  // Acknowledge or reject the load one cycle later; the two are mutually exclusive by construction.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_ack <= load_ok;
      load_err <= load && !load_ok;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] div;
    logic [W-1:0] pend;
    logic         pend_v;
    logic         tick_q;
    logic         sq_q;
    logic         hit;
    logic         wrap;

    // hit: this channel is the target of an accepted load; wrap: last count of the current period.
    always_comb begin
      hit  = load_ok && (load_ch_ext == 32'(i));
      wrap = en[i] && (cnt >= div - W'(1));
    end

    // Count, wrap and swap in a pending divisor only at a period boundary (wrap, sync or while idle).
    always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
        cnt    <= '0;
        div    <= DEF_DIV_W;
        pend   <= '0;
        pend_v <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        if (sync) begin
          cnt    <= '0;
          sq_q   <= 1'b0;
          tick_q <= 1'b0;
          if (pend_v) begin
            div <= pend;
          end
        end else if (en[i]) begin
          if (wrap) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            sq_q   <= ~sq_q;
            if (pend_v) begin
              div <= pend;
            end
          end else begin
            cnt    <= cnt + W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          // Idle channel: nothing to keep in phase, so a new divisor starts a fresh period at once.
          tick_q <= 1'b0;
          if (pend_v) begin
            div <= pend;
            cnt <= '0;
          end
        end

        // A load landing on the same edge as an application becomes the next pending value.
        if (hit) begin
          pend   <= load_div;
          pend_v <= 1'b1;
        end else if (sync || wrap || !en[i]) begin
          pend_v <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Purpose: self-checking bench for clock_div_multi (vector table, corner sequences, random vs reference model).
// Latency: outputs are sampled 1 time unit after each rising edge and compared with that edge's expectation.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_clock_div_multi;

  localparam int W   = 16;
  localparam int CH  = 3;
  localparam int CW  = 2;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          rs  = 1'b1;
  logic [CH-1:0] en  = '0;
  logic          sync = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] load_ch = '0;
  logic [W-1:0]  load_div = '0;
  logic [CH-1:0] tick;
  logic [CH-1:0] sq;
  logic          load_ack;
  logic          load_err;

  clock_div_multi #(.W(W), .CH(CH), .DEF_DIV(DEF), .CW(CW)) dut (
    .clk(clk), .rs(rs), .en(en), .sync(sync), .load(load), .load_ch(load_ch),
    .load_div(load_div), .tick(tick), .sq(sq), .load_ack(load_ack), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: clocks left until the next tick, tick-parity as the square wave, one pending slot.
  int            m_period [CH];
  int            m_left   [CH];
  bit            m_par    [CH];
  bit            m_has    [CH];
  int            m_pval   [CH];
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_sq;
  logic          m_ack;
  logic          m_err;

  typedef struct {
    logic [CH-1:0] en;
    logic          ld;
    logic [CW-1:0] ch;
    logic [W-1:0]  dv;
    logic [CH-1:0] x_tick;
    logic [CH-1:0] x_sq;
    logic          x_ack;
    logic          x_err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_period[i] = DEF;
      m_left[i]   = DEF;
      m_par[i]    = 1'b0;
      m_has[i]    = 1'b0;
      m_pval[i]   = 0;
    end
    m_tick = '0;
    m_sq   = '0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    int ch;
    ch    = int'(load_ch);
    acc   = load && (ch < CH) && (load_div != 0);
    m_ack = acc;
    m_err = load && !acc;
    for (int i = 0; i < CH; i++) begin
      m_tick[i] = 1'b0;
      if (sync) begin
        m_par[i] = 1'b0;
        if (m_has[i]) begin
          m_period[i] = m_pval[i];
          m_has[i]    = 1'b0;
        end
        m_left[i] = m_period[i];
      end else if (en[i]) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_tick[i] = 1'b1;
          m_par[i]  = !m_par[i];
          if (m_has[i]) begin
            m_period[i] = m_pval[i];
            m_has[i]    = 1'b0;
          end
          m_left[i] = m_period[i];
        end
      end else if (m_has[i]) begin
        m_period[i] = m_pval[i];
        m_has[i]    = 1'b0;
        m_left[i]   = m_period[i];
      end
      if (acc && ch == i) begin
        m_pval[i] = int'(load_div);
        m_has[i]  = 1'b1;
      end
      m_sq[i] = m_par[i];
    end
  endtask

  // One clock: predict from the inputs in place, take the edge, compare, drop the strobes.
  task automatic cyc(input string name);
    model_edge();
    @(posedge clk);
    #1;
    check(name, 32'({tick, sq, load_ack, load_err}), 32'({m_tick, m_sq, m_ack, m_err}));
    load = 1'b0;
    sync = 1'b0;
  endtask

  task automatic do_reset();
    rs = 1'b1; en = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    @(posedge clk);
    #1;
    model_reset();
    check("reset_state", 32'({tick, sq, load_ack, load_err}), 32'h0);
    rs = 1'b0;
  endtask

  initial begin
    tbl[0] = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[1] = '{3'b001, 1'b1, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0, 1'b1};
    tbl[2] = '{3'b001, 1'b1, 2'd3, 16'd5, 3'b000, 3'b000, 1'b0, 1'b1};
    tbl[3] = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b001, 3'b001, 1'b0, 1'b0};
    tbl[4] = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b000, 3'b001, 1'b0, 1'b0};
    tbl[5] = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b000, 3'b001, 1'b0, 1'b0};
    tbl[6] = '{3'b001, 1'b1, 2'd0, 16'd0, 3'b000, 3'b001, 1'b0, 1'b1};
    tbl[7] = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b001, 3'b000, 1'b0, 1'b0};
    tbl[8] = '{3'b001, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[9] = '{3'b001, 1'b1, 2'd2, 16'd9, 3'b000, 3'b000, 1'b1, 1'b0};

    // Default divisor timing and rejected loads, edge by edge.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      en = tbl[k].en; load = tbl[k].ld; load_ch = tbl[k].ch; load_div = tbl[k].dv;
      cyc("tbl_model");
      check($sformatf("tbl_row%0d", k), 32'({tick, sq, load_ack, load_err}),
            32'({tbl[k].x_tick, tbl[k].x_sq, tbl[k].x_ack, tbl[k].x_err}));
    end

    // Divisor 4 -> 6 loaded at cnt=1: current period keeps 4, then 6-clock periods.
    do_reset();
    en = 3'b001;
    cyc("r38_e1");
    load = 1'b1; load_ch = 2'd0; load_div = 16'd6;
    cyc("r38_e2");
    check("r38_ack", 32'(load_ack), 32'd1);
    for (int e = 3; e <= 16; e++) begin
      cyc("r38_model");
      check($sformatf("r38_tick_e%0d", e), 32'(tick[0]), 32'(e == 4 || e == 10 || e == 16));
    end

    // Two channels at divisors 3 and 5 restarted together by sync.
    do_reset();
    en = 3'b011;
    load = 1'b1; load_ch = 2'd0; load_div = 16'd3;
    cyc("r40_ld0");
    load = 1'b1; load_ch = 2'd1; load_div = 16'd5;
    cyc("r40_ld1");
    sync = 1'b1;
    cyc("r40_sync");
    check("r40_sync_out", 32'({tick[1:0], sq[1:0]}), 32'h0);
    for (int n = 1; n <= 15; n++) begin
      cyc("r40_model");
      check($sformatf("r40_ticks_n%0d", n), 32'({tick[1], tick[0]}), 32'({n % 5 == 0, n % 3 == 0}));
    end

    // Divisor loaded into an idle channel applies at once; first tick 10 clocks after enabling.
    do_reset();
    en = 3'b001;
    load = 1'b1; load_ch = 2'd1; load_div = 16'd10;
    cyc("r41_ld");
    cyc("r41_apply");
    en = 3'b011;
    for (int n = 1; n <= 10; n++) begin
      cyc("r41_model");
      check($sformatf("r41_tick1_n%0d", n), 32'({tick[1], sq[1]}), 32'({n == 10, n == 10}));
    end

    // Asynchronous reset with a divisor pending and a load on the wire.
    do_reset();
    en = 3'b001;
    for (int n = 0; n < 5; n++) cyc("r42_run");
    load = 1'b1; load_ch = 2'd0; load_div = 16'd7;
    cyc("r42_ld");
    check("r42_pre_sq", 32'({sq[0], load_ack}), 32'h3);
    load = 1'b1; load_ch = 2'd0; load_div = 16'd9;
    #3;
    rs = 1'b1;
    #1;
    check("r42_async", 32'({tick, sq, load_ack, load_err}), 32'h0);
    @(posedge clk);
    #1;
    check("r42_held", 32'({tick, sq, load_ack, load_err}), 32'h0);
    model_reset();
    rs = 1'b0; load = 1'b0; en = 3'b001;
    for (int n = 1; n <= 8; n++) begin
      cyc("r42_model");
      check($sformatf("r42_after_n%0d", n), 32'({tick[0], load_ack}), 32'({n % 4 == 0, 1'b0}));
    end

    // Random traffic against the reference model.
    do_reset();
    en = 3'b111;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) en = CH'($urandom_range(0, 7));
      sync     = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 3) == 0);
      load_ch  = CW'($urandom_range(0, 3));
      load_div = W'($urandom_range(0, 7));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
